argmax_stream: RTL and testbench
================================

// Module: argmax_stream
// PURPOSE
//  Streaming, multi-lane successor to the combinational argmax. Consumes one frame of N
//  M-bit elements, P lanes per beat, over a valid/ready input stream. Emits the frame
//  maximum and its element index on a valid/ready output stream.
//  Sits between a garbled-circuit datapath producer (e.g. a classifier score stage) and
//  the result sink.
// PARAMETERS
//  N       10  elements per frame; N % P == 0 is required, otherwise the build fails.
//  M       32  element bit-width.
//  P       2   lanes per input beat; 1 <= P <= N.
//  SIGNED  0   1: two's-complement compare; 0: unsigned compare.
// PORTS
//  clk        in   1     single clock; all state changes on posedge.
//  rst        in   1     synchronous, active-high reset.
//  in_valid   in   1     input beat valid.
//  in_ready   out  1     input beat accepted when in_valid && in_ready.
//  in_data    in   P*M   lane k = in_data[(k+1)*M-1:k*M]; element index = beat*P+k.
//  out_valid  out  1     result valid.
//  out_ready  in   1     result consumed when out_valid && out_ready.
//  out_max    out  M     frame maximum.
//  out_ind    out  S     index of out_max; S = bits to represent N (log2 fn: N=10 -> 4).
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=ACC, beat_cnt=0, run_max=0, run_ind=0,
//    out_valid=0, out_max=0, out_ind=0. in_ready=1 on the first cycle after reset.
//  - B = N/P beats per frame. beat_cnt counts 0..B-1 and wraps to 0 after the last beat.
//  - Lane reduce (combinational): scan lanes 0..P-1 to get beat max and lane.
//    Default tie rule: the higher index wins, i.e. replace on new >= current.
//  - Beat 0 loads run_max/run_ind directly from the lane result; prior contents are ignored.
//    Beats 1..B-1 compare against the running value with the same tie rule.
//  - States:
//    ACC:  in_ready=1. On the last-beat accept, register the final max/ind into
//          out_max/out_ind, set out_valid=1, go to HOLD.
//    HOLD: out_valid=1; outputs stable until out_ready.
//          in_ready = out_ready, so the first beat of the next frame may be accepted in
//          the same cycle as the result handshake.
//          On out_ready: out_valid=0 next cycle, unless that accepted beat also completes
//          a frame (B=1), in which case out_valid stays 1 with the new result.
//          Go to ACC, or stay in HOLD in the B=1 case.
//  - Latency: last beat accepted at cycle t -> out_valid=1 at t+1.
//    Throughput: one frame per B cycles when out_ready is held 1.
//  - Input stalls: in_valid=0 mid-frame holds beat_cnt and running state.
//  - rst mid-frame: the partial frame is discarded and no result is emitted.
//    rst in HOLD: the pending result is dropped.
//  - out_max/out_ind change only on entry to HOLD; they hold their values after consumption.
// CONFIGURATION
//  ARGMAX_TIE_FIRST_EN: defined -> ties keep the lower index (replace only on new > current),
//    both within a beat and across beats. Undefined -> the higher index wins (default above).
// STRUCTURE
//  argmax_pkg.vh: log2 function, S derivation, ACC/HOLD state encodings, compare macro
//    selecting signed/unsigned and the tie rule.
//  Sub-module argmax_lane_reduce (#(P,M,SIGNED)): combinational P-lane reduce producing
//    max and lane index; instantiated once. Top holds the FSM, beat counter and registers.
// TESTING
//  1 N=10,P=2,unsigned: frame 3,9,1,9,4,0,7,2,8,5 -> max=9, ind=3 (default);
//    ind=1 with ARGMAX_TIE_FIRST_EN.
//  2 SIGNED=1, N=4,P=2,M=8: -5,-2,-9,-3 -> max=-2 (8'hFE), ind=1;
//    SIGNED=0 on the same bits -> max=8'hFE, ind=1 vs 8'hFD... check raw unsigned max = 8'hFE.
//  3 Backpressure: hold out_ready=0 for 5 cycles after frame 1 -> in_ready=0 and outputs stable;
//    then out_ready=1 together with in_valid=1 -> result consumed and next beat accepted
//    in the same cycle.
//  4 Reset mid-frame: after 3 of 5 beats assert rst 1 cycle -> no out_valid;
//    a new full frame 0..9 ascending -> max=9, ind=9.
//  5 P=N=4 (B=1), out_ready=1, in_valid every cycle -> one result per cycle, out_valid stays 1.
//  6 Random: 1000 frames with random in_valid/out_ready vs scoreboard model -> all max/ind match.

Source files
------------

// File: rtl/argmax_pkg.sv
// ============================================================================
//  Module      : argmax_pkg
//  Description : Shared types and helpers for the streaming argmax block.
//                ARGMAX_TIE_FIRST_EN selects the tie rule (lower index wins).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package argmax_pkg;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

`ifdef ARGMAX_TIE_FIRST_EN
    localparam logic c_TIE_LAST = 1'b0;
`else
    localparam logic c_TIE_LAST = 1'b1;
`endif

    // Number of bits needed to hold the value v (never less than one).
    function automatic int bits_for(input int v);
        int b;
        b = 1;
        for (int i = 1; i < 31; i++) begin
            if ((v >> i) != 0) begin
                b = i + 1;
            end
        end
        return b;
    endfunction

    // Replace the current best when the candidate is larger, or equal under the tie-last rule.
    function automatic logic take_new(input logic gt, input logic eq);
        return gt | (eq & c_TIE_LAST);
    endfunction

endpackage

`default_nettype wire

// File: rtl/argmax_lane_reduce.sv
// ============================================================================
//  Module      : argmax_lane_reduce
//  Description : Combinational reduce of P lanes to their maximum and lane index.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module argmax_lane_reduce
    import argmax_pkg::*;
#(
    parameter int P      = 2,
    parameter int M      = 32,
    parameter int SIGNED = 0
) (
    input  logic [P*M-1:0]           lanes,
    output logic [M-1:0]             max_val,
    output logic [bits_for(P-1)-1:0] max_lane
);

    localparam int LW = bits_for(P - 1);

    logic [M-1:0]  w_best;
    logic [LW-1:0] w_lane;
    logic [M-1:0]  w_cand;

    function automatic logic greater(input logic [M-1:0] a, input logic [M-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    always_comb begin
        w_best = lanes[M-1:0];
        w_lane = '0;
        w_cand = '0;
        for (int k = 1; k < P; k++) begin
            w_cand = lanes[k*M +: M];
            if (take_new(greater(w_cand, w_best), w_cand == w_best)) begin
                w_best = w_cand;
                w_lane = LW'(k);
            end
        end
    end

    assign max_val  = w_best;
    assign max_lane = w_lane;

endmodule

`default_nettype wire

// File: rtl/argmax_stream.sv
// ============================================================================
//  Module      : argmax_stream
//  Description : Streaming P-lane argmax over N-element frames, valid/ready on
//                both sides. ARGMAX_TIE_FIRST_EN: ties keep the lower index.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module argmax_stream
    import argmax_pkg::*;
#(
    parameter int N      = 10,
    parameter int M      = 32,
    parameter int P      = 2,
    parameter int SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [P*M-1:0]         in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M-1:0]           out_max,
    output logic [bits_for(N)-1:0] out_ind
);

    localparam int S  = bits_for(N);
    localparam int B  = N / P;
    localparam int BW = bits_for(B - 1);
    localparam int LW = bits_for(P - 1);

    generate
        if ((P < 1) || (P > N) || ((N % P) != 0)) begin : g_bad_cfg
            $error("argmax_stream: P must divide N and satisfy 1 <= P <= N");
        end
    endgenerate

    state_t        r_state;
    logic [BW-1:0] r_beat_cnt;
    logic [M-1:0]  r_run_max;
    logic [S-1:0]  r_run_ind;

    logic [M-1:0]  w_lane_max;
    logic [LW-1:0] w_lane_idx;
    logic [S-1:0]  w_beat_ind;
    logic          w_first;
    logic          w_last;
    logic          w_take;
    logic          w_accept;
    logic [M-1:0]  w_acc_max;
    logic [S-1:0]  w_acc_ind;

    function automatic logic greater(input logic [M-1:0] a, input logic [M-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    argmax_lane_reduce #(
        .P      (P),
        .M      (M),
        .SIGNED (SIGNED)
    ) u_lane_reduce (
        .lanes    (in_data),
        .max_val  (w_lane_max),
        .max_lane (w_lane_idx)
    );

    assign w_beat_ind = S'(r_beat_cnt) * S'(P) + S'(w_lane_idx);
    assign w_first    = (r_beat_cnt == '0);
    assign w_last     = (r_beat_cnt == BW'(B - 1));

    // The first beat of a frame overwrites whatever the previous frame left behind.
    assign w_take    = w_first | take_new(greater(w_lane_max, r_run_max), w_lane_max == r_run_max);
    assign w_acc_max = w_take ? w_lane_max : r_run_max;
    assign w_acc_ind = w_take ? w_beat_ind : r_run_ind;

    // In HOLD the next frame may start only in the cycle the result is taken.
    assign in_ready = (r_state == ST_ACC) | out_ready;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ACC;
            r_beat_cnt <= '0;
            r_run_max  <= '0;
            r_run_ind  <= '0;
            out_valid  <= 1'b0;
            out_max    <= '0;
            out_ind    <= '0;
        end else begin
            if (w_accept) begin
                r_run_max  <= w_acc_max;
                r_run_ind  <= w_acc_ind;
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + BW'(1);
            end
            // A completing beat in HOLD implies out_ready, so it doubles as the handshake.
            if (w_accept && w_last) begin
                out_max   <= w_acc_max;
                out_ind   <= w_acc_ind;
                out_valid <= 1'b1;
                r_state   <= ST_HOLD;
            end else if ((r_state == ST_HOLD) && out_ready) begin
                out_valid <= 1'b0;
                r_state   <= ST_ACC;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_argmax_stream.sv
// ============================================================================
//  Module      : tb_argmax_stream
//  Description : Scoreboard bench for argmax_stream (N=10/P=2 unsigned and
//                N=P=4 signed instances). Honours ARGMAX_TIE_FIRST_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_argmax_stream;

`ifdef ARGMAX_TIE_FIRST_EN
    localparam bit TIE_FIRST = 1'b1;
`else
    localparam bit TIE_FIRST = 1'b0;
`endif

    typedef struct {
        logic [31:0] mx;
        int          ind;
    } exp_t;

    typedef logic [31:0] frame_t [10];

    logic        clk;
    logic        rst;
    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic [63:0] in_data0;
    logic [31:0] out_max0;
    logic [3:0]  out_ind0;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] in_data1;
    logic [7:0]  out_max1;
    logic [2:0]  out_ind1;

    int   errors = 0;
    int   checks = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   rand_ready = 1'b0;
    int   ready_pct  = 60;

    bit          held0 = 1'b0;
    logic [31:0] held_max;
    logic [3:0]  held_ind;

    argmax_stream #(.N(10), .M(32), .P(2), .SIGNED(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .out_max(out_max0), .out_ind(out_ind0)
    );

    argmax_stream #(.N(4), .M(8), .P(4), .SIGNED(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_max(out_max1), .out_ind(out_ind1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic check_eq(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic longint sval(input logic [31:0] x, input int w, input bit sgn);
        logic [63:0] mask;
        longint      v;
        mask = (64'd1 << w) - 64'd1;
        v    = longint'({32'd0, x & mask[31:0]});
        if (sgn && x[w-1]) begin
            v = v - longint'(64'd1 << w);
        end
        return v;
    endfunction

    // Frame maximum by value, then the first or last position holding that value.
    function automatic exp_t ref_argmax(input frame_t e, input int n, input int w, input bit sgn);
        longint best;
        exp_t   r;
        best = sval(e[0], w, sgn);
        for (int i = 1; i < n; i++) begin
            if (sval(e[i], w, sgn) > best) best = sval(e[i], w, sgn);
        end
        r.ind = -1;
        for (int i = 0; i < n; i++) begin
            if (sval(e[i], w, sgn) == best && (!TIE_FIRST || r.ind < 0)) r.ind = i;
        end
        r.mx = e[r.ind];
        return r;
    endfunction

    task automatic push0(input logic [31:0] mx, input int ind);
        exp_t x;
        x.mx  = mx;
        x.ind = ind;
        q0.push_back(x);
    endtask

    task automatic wait_accept0();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready0) break;
            n++;
            if (n > 300) begin
                $display("FAIL accept timeout: in_ready0 stuck low, errors=%0d", errors + 1);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drives beats [first, last] of a frame with random idle gaps.
    task automatic send_beats0(input frame_t e, input int first, input int last, input int gap_pct);
        for (int b = first; b <= last; b++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid0 = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid0 = 1'b1;
            in_data0  = {e[2*b+1], e[2*b]};
            wait_accept0();
        end
        in_valid0 = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready0 = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor for the wide instance: result order, hold stability and backpressure.
    always @(negedge clk) begin
        exp_t x;
        if (!rst && out_valid0) begin
            if (held0) begin
                check_eq("hold max stable", longint'(out_max0), longint'(held_max));
                check_eq("hold ind stable", longint'(out_ind0), longint'(held_ind));
            end
            if (out_ready0) begin
                held0 = 1'b0;
                if (q0.size() == 0) begin
                    check_eq("unexpected result dut0", 1, 0);
                end else begin
                    x = q0.pop_front();
                    check_eq("dut0 max", longint'(out_max0), longint'(x.mx));
                    check_eq("dut0 ind", longint'(out_ind0), longint'(x.ind));
                end
            end else begin
                check_eq("in_ready low while held", longint'(in_ready0), 0);
                held0    = 1'b1;
                held_max = out_max0;
                held_ind = out_ind0;
            end
        end else begin
            held0 = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                check_eq("unexpected result dut1", 1, 0);
            end else begin
                x = q1.pop_front();
                check_eq("dut1 max", longint'(out_max1), longint'(x.mx[7:0]));
                check_eq("dut1 ind", longint'(out_ind1), longint'(x.ind));
            end
        end
    end

    initial begin
        frame_t f;
        frame_t g;
        exp_t   x;
        int     n;

        rst        = 1'b1;
        in_valid0  = 1'b0;
        in_data0   = '0;
        out_ready0 = 1'b1;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset out_valid0", longint'(out_valid0), 0);
        check_eq("reset out_max0", longint'(out_max0), 0);
        check_eq("reset out_ind0", longint'(out_ind0), 0);
        check_eq("reset in_ready0", longint'(in_ready0), 1);
        check_eq("reset out_valid1", longint'(out_valid1), 0);
        check_eq("reset in_ready1", longint'(in_ready1), 1);
        @(posedge clk);
        #1;

        // Directed frame with a repeated maximum.
        f = '{32'd3, 32'd9, 32'd1, 32'd9, 32'd4, 32'd0, 32'd7, 32'd2, 32'd8, 32'd5};
        send_beats0(f, 0, 4, 0);
        push0(32'd9, TIE_FIRST ? 1 : 3);

        // Negative-looking bytes compared unsigned.
        f = '{32'hFB, 32'hFE, 32'hF7, 32'hFD, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        send_beats0(f, 0, 4, 20);
        push0(32'hFE, 1);

        // Backpressure: result held, then consumed alongside the next frame's first beat.
        repeat (4) @(posedge clk);
        #1;
        out_ready0 = 1'b0;
        f = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80, 32'd90, 32'd15};
        send_beats0(f, 0, 4, 0);
        push0(32'd90, 8);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("bp out_valid held", longint'(out_valid0), 1);
        end
        @(posedge clk);
        #1;
        g = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'hFFFF_FFFF};
        out_ready0 = 1'b1;
        in_valid0  = 1'b1;
        in_data0   = {g[1], g[0]};
        @(negedge clk);
        check_eq("bp same-cycle in_ready", longint'(in_ready0), 1);
        check_eq("bp same-cycle out_valid", longint'(out_valid0), 1);
        @(posedge clk);
        #1;
        send_beats0(g, 1, 4, 0);
        push0(32'hFFFF_FFFF, TIE_FIRST ? 0 : 9);

        // Reset mid-frame discards the partial frame.
        repeat (3) @(posedge clk);
        #1;
        f = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500, 32'd600, 32'd700, 32'd800, 32'd900, 32'd1000};
        send_beats0(f, 0, 2, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("post-rst out_valid0", longint'(out_valid0), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) f[i] = 32'(i);
        send_beats0(f, 0, 4, 0);
        push0(32'd9, 9);

        // Random frames under random gaps and backpressure.
        rand_ready = 1'b1;
        for (int fr = 0; fr < 1000; fr++) begin
            for (int i = 0; i < 10; i++) begin
                f[i] = (fr % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            end
            ready_pct = (fr < 500) ? 60 : 90;
            send_beats0(f, 0, 4, 30);
            q0.push_back(ref_argmax(f, 10, 32, 1'b0));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready0 = 1'b1;

        // Single-beat frames, signed compare, continuous streaming.
        in_valid1 = 1'b1;
        in_data1  = {8'hFD, 8'hF7, 8'hFE, 8'hFB};
        @(negedge clk);
        check_eq("dut1 in_ready", longint'(in_ready1), 1);
        x.mx  = 32'hFE;
        x.ind = 1;
        q1.push_back(x);
        @(posedge clk);
        #1;
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 4; k++) begin
                g[k] = (it % 2 == 1) ? 32'(8'($urandom_range(0, 3)) - 8'd2) : 32'($urandom_range(0, 255));
                in_data1[k*8 +: 8] = g[k][7:0];
            end
            @(negedge clk);
            check_eq("dut1 streaming in_ready", longint'(in_ready1), 1);
            check_eq("dut1 out_valid stays high", longint'(out_valid1), 1);
            q1.push_back(ref_argmax(g, 4, 8, 1'b1));
            @(posedge clk);
            #1;
        end
        in_valid1 = 1'b0;

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("dut0 scoreboard drained", longint'(q0.size()), 0);
        check_eq("dut1 scoreboard drained", longint'(q1.size()), 0);
        check_eq("dut1 idle out_valid", longint'(out_valid1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
